// File: rtl/spike_scheduler.sv
// spike_scheduler: sequencer in front of the neural unit.
// Captures one presynaptic spike vector per timestep. It then presents the set
// bits lowest-index-first on spk_addr while en_accum is held, pulses en_activ,
// and waits out the fixed activation sweep before it accepts the next vector.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   in_spk     spike vector for one timestep
//   in_valid   in_spk valid; captured when in_ready is also high
//   in_ready   scheduler idle (decoded from state)
//   spk_addr   index of the spike currently being accumulated
//   en_accum   accumulation phase active
//   en_activ   one-cycle activation start pulse
//   spk_count  popcount of the last captured vector
//   step_done  one-cycle pulse on the last cycle of the timestep
module spike_scheduler #(
    parameter int unsigned PRE_SYN_LAYER_SIZE = 16,
    parameter int unsigned NEURAL_SIZE        = 4,
    parameter int unsigned ACCUM_CYCLES       = 3,
    parameter int unsigned ACTIV_CYCLES       = 2 * NEURAL_SIZE + 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [PRE_SYN_LAYER_SIZE-1:0]           in_spk,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    output logic [$clog2(PRE_SYN_LAYER_SIZE)-1:0]   spk_addr,
    output logic                                    en_accum,
    output logic                                    en_activ,
    output logic [$clog2(PRE_SYN_LAYER_SIZE+1)-1:0] spk_count,
    output logic                                    step_done
);

    localparam int unsigned ADDR_W = $clog2(PRE_SYN_LAYER_SIZE);
    localparam int unsigned CNT_W  = $clog2(PRE_SYN_LAYER_SIZE + 1);
    localparam int unsigned PH_W   = (ACCUM_CYCLES > 1) ? $clog2(ACCUM_CYCLES) : 1;
    localparam int unsigned WT_W   = (ACTIV_CYCLES > 1) ? $clog2(ACTIV_CYCLES) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(ACCUM_CYCLES - 1);
    localparam logic [WT_W-1:0] WT_LAST = WT_W'(ACTIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_ACTIV_ISSUE,
        S_ACTIV_WAIT
    } state_e;

    state_e                        state_q, state_d;
    logic [PRE_SYN_LAYER_SIZE-1:0] pending_q, pending_d;
    logic [ADDR_W-1:0]             spk_addr_q, spk_addr_d;
    logic [CNT_W-1:0]              spk_count_q, spk_count_d;
    logic [PH_W-1:0]               ph_cnt_q, ph_cnt_d;
    logic [WT_W-1:0]               wt_cnt_q, wt_cnt_d;
    logic                          en_accum_q, en_accum_d;
    logic                          en_activ_q, en_activ_d;
    logic                          step_done_q, step_done_d;

    logic [PRE_SYN_LAYER_SIZE-1:0] pending_clr;
    logic [PRE_SYN_LAYER_SIZE-1:0] enc_in;
    logic [ADDR_W-1:0]             enc_idx;
    logic                          enc_any;
    logic [CNT_W-1:0]              pop;

    // One priority encoder is shared. In IDLE it looks at the incoming vector.
    // Otherwise it looks at the pending set with the current spike removed.
    always_comb begin
        pending_clr              = pending_q;
        pending_clr[spk_addr_q]  = 1'b0;
        enc_in  = (state_q == S_IDLE) ? in_spk : pending_clr;
        enc_any = |enc_in;
        enc_idx = '0;
        for (int i = PRE_SYN_LAYER_SIZE - 1; i >= 0; i--) begin
            if (enc_in[i]) enc_idx = ADDR_W'(i);
        end
        pop = '0;
        for (int i = 0; i < PRE_SYN_LAYER_SIZE; i++) begin
            pop = pop + CNT_W'(in_spk[i]);
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        spk_addr_d  = spk_addr_q;
        spk_count_d = spk_count_q;
        ph_cnt_d    = ph_cnt_q;
        wt_cnt_d    = wt_cnt_q;
        en_accum_d  = 1'b0;
        en_activ_d  = 1'b0;
        step_done_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    pending_d   = in_spk;
                    spk_count_d = pop;
                    spk_addr_d  = enc_idx;
                    ph_cnt_d    = '0;
                    if (enc_any) begin
                        state_d    = S_ACCUM;
                        en_accum_d = 1'b1;
                    end else begin
                        state_d    = S_ACTIV_ISSUE;
                    end
                end
            end
            S_ACCUM: begin
                en_accum_d = 1'b1;
                if (ph_cnt_q == PH_LAST) begin
                    pending_d = pending_clr;
                    ph_cnt_d  = '0;
                    if (enc_any) begin
                        spk_addr_d = enc_idx;
                    end else begin
                        state_d    = S_ACTIV_ISSUE;
                        en_accum_d = 1'b0;
                    end
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            S_ACTIV_ISSUE: begin
                // en_accum low for one cycle before the activation pulse
                state_d     = S_ACTIV_WAIT;
                en_activ_d  = 1'b1;
                wt_cnt_d    = '0;
                step_done_d = (WT_LAST == '0);
            end
            S_ACTIV_WAIT: begin
                if (wt_cnt_q == WT_LAST) begin
                    state_d  = S_IDLE;
                    wt_cnt_d = '0;
                end else begin
                    wt_cnt_d    = wt_cnt_q + WT_W'(1);
                    step_done_d = ((wt_cnt_q + WT_W'(1)) == WT_LAST);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pending_q   <= '0;
            spk_addr_q  <= '0;
            spk_count_q <= '0;
            ph_cnt_q    <= '0;
            wt_cnt_q    <= '0;
            en_accum_q  <= 1'b0;
            en_activ_q  <= 1'b0;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            spk_addr_q  <= spk_addr_d;
            spk_count_q <= spk_count_d;
            ph_cnt_q    <= ph_cnt_d;
            wt_cnt_q    <= wt_cnt_d;
            en_accum_q  <= en_accum_d;
            en_activ_q  <= en_activ_d;
            step_done_q <= step_done_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign spk_addr  = spk_addr_q;
    assign spk_count = spk_count_q;
    assign en_accum  = en_accum_q;
    assign en_activ  = en_activ_q;
    assign step_done = step_done_q;

endmodule

// File: tb/tb_spike_scheduler.sv
// tb_spike_scheduler: self-checking bench for spike_scheduler.
// For each timestep, the reference derives the whole output trace from the
// list of set indices: each spike gets ACC cycles, followed by one gap cycle,
// the activation pulse, and the activation sweep.
module tb_spike_scheduler;

    localparam int unsigned NPRE = 16;
    localparam int unsigned NS   = 4;
    localparam int unsigned ACC  = 3;
    localparam int unsigned ACT  = 2 * NS + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_spk;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  spk_addr;
    logic        en_accum;
    logic        en_activ;
    logic [4:0]  spk_count;
    logic        step_done;

    int errors = 0;
    int checks = 0;

    spike_scheduler #(
        .PRE_SYN_LAYER_SIZE(NPRE),
        .NEURAL_SIZE       (NS),
        .ACCUM_CYCLES      (ACC),
        .ACTIV_CYCLES      (ACT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_spk   (in_spk),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .spk_addr (spk_addr),
        .en_accum (en_accum),
        .en_activ (en_activ),
        .spk_count(spk_count),
        .step_done(step_done)
    );

    always #5 clk = ~clk;

    // Compare every output against its reset value
    task automatic check_reset_vals(input string tag);
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL %s in_ready got=%b exp=1", tag, in_ready); end
        checks++; if (en_accum !== 1'b0)  begin errors++; $display("FAIL %s en_accum got=%b exp=0", tag, en_accum); end
        checks++; if (en_activ !== 1'b0)  begin errors++; $display("FAIL %s en_activ got=%b exp=0", tag, en_activ); end
        checks++; if (step_done !== 1'b0) begin errors++; $display("FAIL %s step_done got=%b exp=0", tag, step_done); end
        checks++; if (spk_addr !== 4'd0)  begin errors++; $display("FAIL %s spk_addr got=%0d exp=0", tag, spk_addr); end
        checks++; if (spk_count !== 5'd0) begin errors++; $display("FAIL %s spk_count got=%0d exp=0", tag, spk_count); end
    endtask

    // Check one timestep. The caller returns just after the capture edge.
    // With hold set, in_valid is held high with noise on in_spk during
    // activation, and nxt is presented on the first IDLE cycle.
    task automatic trace(input logic [15:0] v, input bit hold, input logic [15:0] nxt, input string tag);
        int idx[$];
        int n;
        int l;
        for (int i = 0; i < 16; i++) if (v[i]) idx.push_back(i);
        n = idx.size();
        l = ACC * n;
        for (int t = 0; t <= l + ACT + 1; t++) begin
            @(negedge clk);
            if (t <= l + ACT) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s in_ready t=%0d got=%b exp=0", tag, t, in_ready); end
                checks++; if (en_accum !== (t < l)) begin errors++; $display("FAIL %s en_accum t=%0d got=%b exp=%b", tag, t, en_accum, (t < l)); end
                checks++; if (en_activ !== (t == l + 1)) begin errors++; $display("FAIL %s en_activ t=%0d got=%b exp=%b", tag, t, en_activ, (t == l + 1)); end
                checks++; if (step_done !== (t == l + ACT)) begin errors++; $display("FAIL %s step_done t=%0d got=%b exp=%b", tag, t, step_done, (t == l + ACT)); end
                checks++; if (spk_count !== 5'(n)) begin errors++; $display("FAIL %s spk_count t=%0d got=%0d exp=%0d", tag, t, spk_count, n); end
                if (t < l) begin
                    checks++;
                    if (spk_addr !== 4'(idx[t / ACC])) begin
                        errors++; $display("FAIL %s spk_addr t=%0d got=%0d exp=%0d", tag, t, spk_addr, idx[t / ACC]);
                    end
                end
            end else begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready_rise t=%0d got=%b exp=1", tag, t, in_ready); end
                checks++; if (en_activ !== 1'b0) begin errors++; $display("FAIL %s en_activ_idle got=%b exp=0", tag, en_activ); end
                checks++; if (step_done !== 1'b0) begin errors++; $display("FAIL %s step_done_idle got=%b exp=0", tag, step_done); end
            end
            if (hold && t >= l + 1) begin
                in_valid = 1'b1;
                in_spk   = (t == l + ACT + 1) ? nxt : 16'($urandom);
            end
        end
    endtask

    task automatic send(input logic [15:0] v, input bit hold, input logic [15:0] nxt, input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_timeout got=%b exp=1", tag, in_ready);
        end
        in_spk   = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_spk   = 16'($urandom);
        trace(v, hold, nxt, tag);
        if (hold) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            trace(nxt, 1'b0, 16'h0, {tag, "_next"});
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_spk   = 16'h0;
        #1;
        check_reset_vals("reset_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset_release");
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            in_spk = 16'($urandom);
            @(negedge clk);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle in_ready c=%0d got=%b exp=1", i, in_ready); end
            checks++; if ({en_accum, en_activ, step_done} !== 3'b000) begin
                errors++; $display("FAIL idle pulses c=%0d got=%b exp=000", i, {en_accum, en_activ, step_done});
            end
        end
    endtask

    task automatic test_patterns();
        send(16'h0000, 1'b0, 16'h0, "zero");
        send(16'h8421, 1'b0, 16'h0, "p8421");
        send(16'hFFFF, 1'b0, 16'h0, "ones");
        send(16'h8000, 1'b0, 16'h0, "top_bit");
    endtask

    task automatic test_random();
        logic [15:0] v;
        for (int i = 0; i < 8; i++) begin
            case (i % 3)
                0:       v = 16'($urandom);
                1:       v = 16'($urandom) & 16'($urandom) & 16'($urandom);
                default: v = 16'($urandom) | 16'($urandom);
            endcase
            send(v, 1'b0, 16'h0, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_spk   = 16'h8421;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int t = 0; t <= 4; t++) @(negedge clk);
        checks++; if (en_accum !== 1'b1) begin errors++; $display("FAIL rst_mid pre_en_accum got=%b exp=1", en_accum); end
        checks++; if (spk_addr !== 4'd5) begin errors++; $display("FAIL rst_mid pre_spk_addr got=%0d exp=5", spk_addr); end
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("rst_mid_async");
        @(negedge clk);
        rst = 1'b0;
        send(16'h0002, 1'b0, 16'h0, "after_rst");
    endtask

    task automatic test_back_to_back();
        send(16'h1234, 1'b1, 16'($urandom), "hold_a");
        send(16'hC003, 1'b1, 16'h0000, "hold_b");
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle();
        test_patterns();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spike_scheduler.md
# spike_scheduler

Upstream sequencer for the neural unit. Accepts one presynaptic spike vector per timestep, serialises its set bits lowest-index-first into `spk_addr` while holding `en_accum`, then issues an `en_activ` pulse. It waits out the neural unit's fixed activation sweep before accepting the next timestep. All handshake timing toward the neural unit is fixed-cycle, with no back-channel from it.

## Interface
Parameters:
- `PRE_SYN_LAYER_SIZE`, 16: width of the spike vector; number of presynaptic neurons.
- `NEURAL_SIZE`, 4: neurons in the downstream unit; sets the activation wait.
- `ACCUM_CYCLES`, 3: cycles the downstream unit spends per spike (fetch, read, accumulate).
- `ACTIV_CYCLES`, 2*NEURAL_SIZE+1: cycles from the `en_activ` pulse until the downstream unit is idle again.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. Asynchronous and active-high.
- `in_spk`, in, PRE_SYN_LAYER_SIZE: spike vector for one timestep.
- `in_valid`, in, 1: `in_spk` valid.
- `in_ready`, out, 1: scheduler idle; capture on `in_valid & in_ready`.
- `spk_addr`, out, $clog2(PRE_SYN_LAYER_SIZE): index of the current spike.
- `en_accum`, out, 1: accumulation phase active.
- `en_activ`, out, 1: one-cycle pulse that starts activation.
- `spk_count`, out, $clog2(PRE_SYN_LAYER_SIZE+1): number of set bits in the last captured vector.
- `step_done`, out, 1: one-cycle pulse when the timestep is complete.

## Operation
- States: IDLE, ACCUM, ACTIV_ISSUE, ACTIV_WAIT.
- IDLE
  - `in_ready`=1.
  - On handshake at edge C: latch `in_spk` into `pending`, latch its popcount into `spk_count`, and load the lowest set index into `spk_addr`.
  - Nonzero vector: go to ACCUM.
  - Zero vector: go to ACTIV_ISSUE.
- ACCUM
  - `en_accum`=1.
  - A phase counter counts 0..ACCUM_CYCLES-1.
  - At count ACCUM_CYCLES-1:
    - clear the current bit in `pending`;
    - if `pending` still has set bits, load the next lowest set index into `spk_addr` and restart the counter;
    - otherwise go to ACTIV_ISSUE.
- ACTIV_ISSUE
  - Lasts one cycle with `en_accum`=0, letting the downstream unit return to its wait state.
  - Then go to ACTIV_WAIT, asserting `en_activ` for exactly the first ACTIV_WAIT cycle.
- ACTIV_WAIT
  - Counts ACTIV_CYCLES cycles starting at the `en_activ` cycle.
  - On the last one, pulse `step_done`, then go to IDLE.
- Lowest-set-bit search is a combinational priority encoder over `pending`; popcount is combinational on `in_spk`.
- `in_spk` changes while not in IDLE are ignored.
- `in_valid` with `in_ready`=0 is not captured. The source holds it.

## Timing
- Reset (asynchronous, any state, including mid-ACCUM):
  - state=IDLE, `pending`=0, counters=0.
  - `in_ready`=1, `en_accum`=0, `en_activ`=0, `step_done`=0, `spk_addr`=0, `spk_count`=0.
  - Outputs take these values immediately, not at the next edge.
- All outputs are registered except `in_ready`, which is decoded from state.
- With N≥1 spikes captured at edge C, and T0=C+1:
  - spike k's address is stable during cycles T0+3k..T0+3k+2 (ACCUM_CYCLES=3);
  - `en_accum`=1 during T0..T0+3N-1 and 0 at T0+3N;
  - `en_activ` is high at T0+3N+1 only;
  - `step_done` is high at T0+3N+ACTIV_CYCLES;
  - `in_ready` rises at T0+3N+ACTIV_CYCLES+1.
- Zero spikes: `en_activ` at C+2 and `step_done` at C+1+ACTIV_CYCLES; `en_accum` never rises.
- Back-to-back timesteps: a new capture is possible on the first IDLE cycle, giving no bubble beyond the above.
- Bit PRE_SYN_LAYER_SIZE-1 set:
  - `spk_addr` reaches its maximum value;
  - all-ones vector gives `spk_count`=PRE_SYN_LAYER_SIZE with no overflow of the extra bit.
- `en_accum` and `en_activ` are never high in the same cycle.

## Test plan
- Reset, then idle:
  - all outputs hold their reset values;
  - `in_valid`=0 for 10 cycles leaves `in_ready`=1 with no pulses.
- `in_spk`=16'h0000 → `spk_count`=0, `en_accum` never high, `en_activ` at C+2, `step_done` at C+10 (NEURAL_SIZE=4).
- `in_spk`=16'h8421 → `spk_addr` sequence 0,5,10,15 with 3 cycles each, `en_accum` high 12 cycles, `en_activ` at T0+13, `step_done` at T0+21, `spk_count`=4.
- `in_spk`=16'hFFFF → `spk_addr` steps 0..15, `en_accum` high 48 cycles, `spk_count`=16.
- Assert `rst` at T0+4 during 16'h8421, release, then send 16'h0002:
  - outputs clear asynchronously;
  - the next timestep emits only `spk_addr`=1;
  - no stale bits from the aborted vector appear.
- Hold `in_valid`=1 with changing `in_spk` during ACTIV_WAIT → nothing captured until `in_ready`; the vector present at the first IDLE edge is captured.
